// File: rtl/prga_sync_fifo_if.sv
// Handshake bundle for prga_sync_fifo: the write side (wr/din/full) and the read side (rd/dout/empty).
// The master is the producer/consumer logic and the slave is the FIFO itself.
interface prga_sync_fifo_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  full;
    logic                  wr;
    logic [DATA_WIDTH-1:0] din;
    logic                  empty;
    logic                  rd;
    logic [DATA_WIDTH-1:0] dout;

    modport master (
        input  full,
        input  empty,
        input  dout,
        output wr,
        output din,
        output rd
    );

    modport slave (
        input  wr,
        input  din,
        input  rd,
        output full,
        output empty,
        output dout
    );
endinterface

// File: rtl/prga_sync_fifo.sv
// Single-clock FIFO with a block-RAM core and a registered read port; LOOKAHEAD=1 reuses that
// read register as a one-entry prefetch stage (FWFT). Define PRGA_FIFO_CHECK_EN for overflow/underflow messages.
module prga_sync_fifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int DATA_WIDTH = 32,
    parameter int LOOKAHEAD  = 0
) (
    input  logic             clk,
    input  logic             rst,
    prga_sync_fifo_if.slave  fifo
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr_reg;
    logic [DEPTH_LOG2:0]   rd_ptr_reg;
    logic [DATA_WIDTH-1:0] dout_reg;

    logic core_empty;
    logic core_full;
    logic core_wr;
    logic core_rd;

    // The extra MSB distinguishes a full core from an empty one when the addresses match.
    assign core_empty = (rd_ptr_reg == wr_ptr_reg);
    assign core_full  = (rd_ptr_reg[DEPTH_LOG2-1:0] == wr_ptr_reg[DEPTH_LOG2-1:0]) &&
                        (rd_ptr_reg[DEPTH_LOG2] != wr_ptr_reg[DEPTH_LOG2]);
    assign core_wr    = fifo.wr && !core_full;

    assign fifo.full  = core_full;
    assign fifo.dout  = dout_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (core_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (core_rd) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Storage is left unreset so it maps onto block RAM; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (core_wr) begin
            mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= fifo.din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_reg <= '0;
        end else if (core_rd) begin
            dout_reg <= mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
        end
    end

    generate
        if (LOOKAHEAD != 0) begin : g_lookahead
            logic valid_reg;
            logic valid_next;
            logic pop;

            // dout_reg doubles as the prefetch register: refill whenever it is empty or being drained.
            assign pop        = fifo.rd && valid_reg;
            assign core_rd    = !core_empty && (!valid_reg || pop);
            assign fifo.empty = !valid_reg;

            always_comb begin
                valid_next = valid_reg;
                if (core_rd) begin
                    valid_next = 1'b1;
                end else if (pop) begin
                    valid_next = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                end else begin
                    valid_reg <= valid_next;
                end
            end
        end else begin : g_plain
            assign core_rd    = fifo.rd && !core_empty;
            assign fifo.empty = core_empty;
        end
    endgenerate

`ifdef PRGA_FIFO_CHECK_EN
    always @(posedge clk) begin
        if (fifo.wr && fifo.full) begin
            $display("[ERROR] prga_sync_fifo overflow");
        end
        if (fifo.rd && fifo.empty) begin
            $display("[ERROR] prga_sync_fifo underflow");
        end
    end
`else
    // Illegal requests are silently ignored by the logic above.
`endif

endmodule

// File: tb/tb_prga_sync_fifo.sv
// Drives a non-lookahead and a lookahead FIFO (DEPTH_LOG2=2, 8-bit) with identical stimulus
// and compares both against fixed vectors and a queue-based scoreboard.
module tb_prga_sync_fifo;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prga_sync_fifo_if #(.DATA_WIDTH(8)) nl_if ();
    prga_sync_fifo_if #(.DATA_WIDTH(8)) la_if ();

    prga_sync_fifo #(.DEPTH_LOG2(2), .DATA_WIDTH(8), .LOOKAHEAD(0)) u_nl (
        .clk  (clk),
        .rst  (rst),
        .fifo (nl_if.slave)
    );

    prga_sync_fifo #(.DEPTH_LOG2(2), .DATA_WIDTH(8), .LOOKAHEAD(1)) u_la (
        .clk  (clk),
        .rst  (rst),
        .fifo (la_if.slave)
    );

    typedef struct {
        bit         wr;
        logic [7:0] din;
        bit         rd;
        bit         nl_e;
        bit         nl_f;
        logic [7:0] nl_d;
        bit         la_e;
        bit         la_f;
        logic [7:0] la_d;
    } vec_t;

    vec_t tbl [12];

    int errors = 0;
    int checks = 0;
    int txn    = 0;

    // Scoreboard state: NL queue of stored words, LA queue of all words (prefetched word first).
    logic [7:0] nl_q [$];
    logic [7:0] la_q [$];
    bit         la_v;
    logic [7:0] nl_exp;
    logic [7:0] la_exp;

    logic [7:0] src [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit w, input logic [7:0] d, input bit r);
        nl_if.wr  = w;
        nl_if.din = d;
        nl_if.rd  = r;
        la_if.wr  = w;
        la_if.din = d;
        la_if.rd  = r;
    endtask

    task automatic show(input bit w, input logic [7:0] d, input bit r);
        txn++;
        $display("txn %0d rst=%b wr=%b din=%h rd=%b | nl empty=%b full=%b dout=%h | la empty=%b full=%b dout=%h",
                 txn, rst, w, d, r, nl_if.empty, nl_if.full, nl_if.dout,
                 la_if.empty, la_if.full, la_if.dout);
    endtask

    task automatic do_reset(input int edges);
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < edges; i++) begin
            @(posedge clk);
        end
        #1;
        nl_q.delete();
        la_q.delete();
        la_v   = 1'b0;
        nl_exp = 8'h00;
        la_exp = 8'h00;
        show(1'b0, 8'h00, 1'b0);
        chk("rst_nl_empty", nl_if.empty, 1);
        chk("rst_nl_full",  nl_if.full,  0);
        chk("rst_nl_dout",  nl_if.dout,  0);
        chk("rst_la_empty", la_if.empty, 1);
        chk("rst_la_full",  la_if.full,  0);
        chk("rst_la_dout",  la_if.dout,  0);
        rst = 1'b0;
    endtask

    // One clock of stimulus to both FIFOs, with the expected outcome predicted first.
    task automatic cycle(input bit w, input logic [7:0] d, input bit r);
        bit nl_w, nl_r, la_w, la_p, la_fill;
        int la_core;
        nl_w = w && (nl_q.size() < 4);
        nl_r = r && (nl_q.size() > 0);
        if (nl_r) nl_exp = nl_q.pop_front();
        if (nl_w) nl_q.push_back(d);

        la_core = la_q.size() - (la_v ? 1 : 0);
        la_w    = w && (la_core < 4);
        la_p    = r && la_v;
        la_fill = (la_core > 0) && (!la_v || la_p);
        if (la_p) void'(la_q.pop_front());
        if (la_w) la_q.push_back(d);
        la_v = la_fill ? 1'b1 : (la_p ? 1'b0 : la_v);
        if (la_v) la_exp = la_q[0];

        drive(w, d, r);
        @(posedge clk);
        #1;
        show(w, d, r);
        chk("sb_nl_empty", nl_if.empty, (nl_q.size() == 0) ? 1 : 0);
        chk("sb_nl_full",  nl_if.full,  (nl_q.size() == 4) ? 1 : 0);
        chk("sb_nl_dout",  nl_if.dout,  nl_exp);
        chk("sb_la_empty", la_if.empty, la_v ? 0 : 1);
        chk("sb_la_full",  la_if.full,  ((la_q.size() - (la_v ? 1 : 0)) == 4) ? 1 : 0);
        chk("sb_la_dout",  la_if.dout,  la_exp);
        drive(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        src[0] = 8'h5A; src[1] = 8'hF6; src[2] = 8'h09; src[3] = 8'hC4;
        src[4] = 8'h81; src[5] = 8'hE2; src[6] = 8'hA0; src[7] = 8'h7A;

        //             wr din    rd  nl:e f dout   la:e f dout
        tbl[0]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 8'hF6, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A};
        tbl[2]  = '{1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A};
        tbl[3]  = '{1'b1, 8'hC4, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h5A};
        tbl[4]  = '{1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h5A};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 8'hF6};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hF6, 1'b0, 1'b0, 8'h09};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h09, 1'b0, 1'b0, 8'hC4};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hC4, 1'b0, 1'b0, 8'h81};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hC4, 1'b1, 1'b0, 8'h81};
        tbl[10] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'hC4, 1'b1, 1'b0, 8'h81};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C};

        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        do_reset(2);

        // Fixed vectors: order, full/drop, read-while-empty, write+read-while-empty.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].wr, tbl[i].din, tbl[i].rd);
            @(posedge clk);
            #1;
            show(tbl[i].wr, tbl[i].din, tbl[i].rd);
            chk($sformatf("vec%0d_nl_empty", i), nl_if.empty, tbl[i].nl_e);
            chk($sformatf("vec%0d_nl_full",  i), nl_if.full,  tbl[i].nl_f);
            chk($sformatf("vec%0d_nl_dout",  i), nl_if.dout,  tbl[i].nl_d);
            chk($sformatf("vec%0d_la_empty", i), la_if.empty, tbl[i].la_e);
            chk($sformatf("vec%0d_la_full",  i), la_if.full,  tbl[i].la_f);
            chk($sformatf("vec%0d_la_dout",  i), la_if.dout,  tbl[i].la_d);
            drive(1'b0, 8'h00, 1'b0);
        end

        // Continuous writes while popping whenever the lookahead FIFO shows data.
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, src[i], la_v);
        end
        for (int i = 0; i < 12 && la_q.size() > 0; i++) begin
            cycle(1'b0, 8'h00, la_v);
        end
        chk("la_stream_drained", la_q.size(), 0);

        // Three fill/drain rounds so both pointers wrap more than once.
        do_reset(1);
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < 4; i++) begin
                cycle(1'b1, src[(round * 4 + i) % 8], 1'b0);
            end
            for (int i = 0; i < 4; i++) begin
                cycle(1'b0, 8'h00, 1'b1);
            end
        end

        // Simultaneous read+write at count 2, then reset with three words in flight.
        do_reset(1);
        cycle(1'b1, 8'hA1, 1'b0);
        cycle(1'b1, 8'hB2, 1'b0);
        cycle(1'b1, 8'hC3, 1'b1);
        cycle(1'b1, 8'hD4, 1'b1);
        cycle(1'b1, 8'hE5, 1'b0);
        do_reset(1);
        cycle(1'b1, 8'h6F, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
